// File: rtl/dla_hld_ram_stream_reader_pkg.sv
// Shared types and helpers for the RAM stream reader: FSM state encoding,
// address-width helper and the stall counter width.
package dla_hld_ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int STALL_W = 32;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dla_hld_ram_stream_reader_fifo.sv
// Prefetch FIFO with registered storage/pointers; the head entry is read
// straight from the storage registers so it holds steady until popped.
module dla_hld_ram_stream_reader_fifo
  import dla_hld_ram_stream_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = addr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  always_ff @(posedge clock) begin
    if (resetn) begin
      assert (!(push && !pop && (cnt_q == CNT_W'(DEPTH))));
      assert (!(pop && (cnt_q == '0)));
    end
  end

endmodule

// File: rtl/dla_hld_ram_stream_reader.sv
// Credit-limited read client for a fixed-latency RAM port, returning data as a
// valid/ready stream. Optional stall counter: DLA_HLD_RAM_STREAM_READER_STALL_COUNT_EN.
module dla_hld_ram_stream_reader
  import dla_hld_ram_stream_reader_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR         = addr_w(DEPTH)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR-1:0]    cmd_address,
  input  logic [ADDR:0]      cmd_length,
  output logic [ADDR-1:0]    ram_address,
  output logic               ram_read_enable,
  input  logic [WIDTH-1:0]   ram_readdata,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_last,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count
);
  localparam int CW    = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  if ((FIFO_DEPTH < READ_LATENCY + 1) || (READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_cfg_check
    $error("dla_hld_ram_stream_reader: need 1<=READ_LATENCY<=4 and FIFO_DEPTH>=READ_LATENCY+1");
  end

  state_e                  state_q, state_d;
  logic [ADDR-1:0]         addr_q, addr_d;
  logic [ADDR:0]           rem_q, rem_d;
  logic [READ_LATENCY-1:0] sr_vld_q, sr_vld_d, sr_last_q, sr_last_d;
  logic                    init_q, init_d;
  logic [CW-1:0]           inflight;
  logic [OCC_W-1:0]        occ;
  logic                    fifo_empty, credit_ok, issue, cmd_accept, push, pop;
  logic [WIDTH:0]          head;

  // Every word already issued but not yet popped holds a FIFO slot in reserve.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(sr_vld_q[i]);
  end

  assign credit_ok  = (inflight + CW'(occ) + CW'(1)) <= CW'(FIFO_DEPTH);
  assign issue      = (state_q == ISSUE) && (rem_q != '0) && credit_ok;
  assign cmd_ready  = init_q && (state_q == IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    init_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d = cmd_address;
          rem_d  = cmd_length;
          if (cmd_length != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latency shadow: the strobe and last tag line up with ram_readdata at the tail.
  always_comb begin
    sr_vld_d     = '0;
    sr_last_d    = '0;
    sr_vld_d[0]  = issue;
    sr_last_d[0] = issue && (rem_q == (ADDR + 1)'(1));
    for (int i = 1; i < READ_LATENCY; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_last_d[i] = sr_last_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      sr_vld_q  <= '0;
      sr_last_q <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      sr_vld_q  <= sr_vld_d;
      sr_last_q <= sr_last_d;
      init_q    <= init_d;
    end
  end

  assign push = sr_vld_q[READ_LATENCY-1];
  assign pop  = o_valid && o_ready;

  dla_hld_ram_stream_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WIDTH + 1),
    .CNT_W (OCC_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wdata  ({sr_last_q[READ_LATENCY-1], ram_readdata}),
    .pop    (pop),
    .rdata  (head),
    .empty  (fifo_empty),
    .count  (occ)
  );

  assign ram_address     = addr_q;
  assign ram_read_enable = issue;
  assign o_valid         = !fifo_empty;
  assign o_data          = head[WIDTH-1:0];
  assign o_last          = head[WIDTH];
  assign busy            = (state_q != IDLE);

`ifdef DLA_HLD_RAM_STREAM_READER_STALL_COUNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cmd_accept) stall_d = '0;
    else if (o_valid && !o_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: doc/dla_hld_ram_stream_reader.md
Name: dla_hld_ram_stream_reader

Overview:
- Read-side client for a dla_hld_ram port.
- Accepts a command (start address, word count) and issues one read per cycle to a fixed-latency RAM port.
- Returns the data as a valid/ready stream with last marking.
- The RAM read pipeline cannot stall, so reads are credit-limited against an internal prefetch FIFO; downstream backpressure never loses data.

Parameters:
- DEPTH, 1024, RAM depth in words; ADDR = $clog2(DEPTH).
- WIDTH, 32, RAM/stream data width.
- READ_LATENCY, 2, cycles from ram_read_enable to valid ram_readdata (1..4).
- FIFO_DEPTH, 4, prefetch FIFO entries; must be >= READ_LATENCY+1 (parameter assert).

Ports:
- clock  input  1  sole clock.
- resetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when both high.
- cmd_address  input  ADDR  first word address.
- cmd_length  input  ADDR+1  word count, 0..DEPTH.
- ram_address  output  ADDR  RAM read address.
- ram_read_enable  output  1  RAM read strobe.
- ram_readdata  input  WIDTH  RAM data, READ_LATENCY after strobe.
- o_valid  output  1  stream data valid.
- o_ready  input  1  downstream accepts.
- o_data  output  WIDTH  stream data.
- o_last  output  1  final word of command.
- busy  output  1  command in progress or data pending.
- stall_count  output  32  cycles with o_valid=1 and o_ready=0 (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert via clock):
  - cmd_ready=0, then 1 on the first cycle after deassert.
  - ram_read_enable=0, ram_address=0, o_valid=0, o_last=0, o_data=0, busy=0, stall_count=0.
  - FIFO, credit counter and latency shift register are all cleared.
- States:
  - IDLE: cmd_ready=1. On accept, latch address and remaining=cmd_length. Go to ISSUE if length>0; otherwise stay in IDLE (no reads, no output).
  - ISSUE: assert ram_read_enable whenever remaining>0 and inflight+occupancy < FIFO_DEPTH. Each issue increments the address modulo DEPTH (DEPTH-1 wraps to 0) and decrements remaining. Go to DRAIN the cycle after the final issue.
  - DRAIN: wait for inflight==0 and FIFO empty, then go to IDLE. cmd_ready is 0 in ISSUE and DRAIN.
- Latency tracking:
  - A READ_LATENCY-deep shift register carries the read strobe plus a last tag.
  - On its output, ram_readdata and the last tag are pushed into the FIFO.
  - inflight = number of set strobes in the shift register.
- Credits:
  - issue allowed iff inflight + occupancy + 1 <= FIFO_DEPTH. This guarantees a push never meets a full FIFO.
  - Overflow is an assertion failure.
- Stream:
  - o_valid = FIFO non-empty; o_data and o_last come from the FIFO head.
  - Pop on o_valid&&o_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Data must hold stable while o_valid=1 and o_ready=0.
- Throughput: with o_ready held high, one word per cycle. The first o_valid appears READ_LATENCY+1 cycles after the accepting edge (FIFO output registered).
- busy = state!=IDLE.
- Length DEPTH reads every word exactly once, starting at cmd_address and wrapping.
- Reset asserted mid-command aborts everything immediately. No partial output after reset; the first post-reset word comes from a new command.

Optional Feature:
- Macro: DLA_HLD_RAM_STREAM_READER_STALL_COUNT_EN.
- Defined: stall_count is a saturating 32-bit counter of o_valid&&!o_ready cycles. It is cleared by reset and on each command accept.
- Undefined: stall_count is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package dla_hld_ram_stream_reader_pkg:
  - state enum (IDLE, ISSUE, DRAIN).
  - function computing ADDR from DEPTH.
  - localparam for the stall counter width (32).
- One sub-module: dla_hld_ram_stream_reader_fifo, a registered-output FIFO of FIFO_DEPTH x (WIDTH+1) with count output. It asserts on overflow and underflow.

Test Plan:
- RAM model with READ_LATENCY=2, mem[i]=i. Command addr=5, len=4, o_ready=1 -> data 5,6,7,8 on consecutive cycles; o_last only on 8; first o_valid 3 cycles after accept.
- DEPTH=16, addr=14, len=4 -> ram_address sequence 14,15,0,1; data 14,15,0,1.
- len=0 -> no ram_read_enable, no o_valid, cmd_ready high again the next cycle.
- len=10 with o_ready toggling 1-of-3 cycles -> all 10 words in order, no loss or duplication, inflight+occupancy never exceeds 4. With the macro defined, stall_count equals the number of o_valid&&!o_ready cycles.
- len=DEPTH=16 at addr=3 -> every word read once, 16 outputs, last on word 2.
- Assert resetn low during ISSUE of len=8 -> all outputs reset asynchronously. A new command addr=0, len=2 then yields exactly 0,1.
